// File: rtl/full_event_recorder.sv
// full_event_recorder: measures runs of consecutive high samples on sig
// (the upstream "volume full" indicator) and queues {saturated, length}
// records in a small FIFO for a downstream consumer. Also keeps a wrapping
// count of completed runs and a saturating count of records lost to a full
// FIFO.
module full_event_recorder #(
    parameter int LBITS = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [LBITS:0]   out_data,
    output logic [7:0]       evt_count,
    output logic [7:0]       drop_count,
    output logic             busy
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LBITS-1:0] len;
    logic [LBITS-1:0] len_next;
    logic             sat;
    logic             sat_next;
    logic             push;

    logic [LBITS:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [PW:0]      count_next;
    logic             full;
    logic             pop;
    logic             store;
    logic             drop;

    // Run measurement: next state, length/saturation update, completion push.
    always_comb begin
        state_next = state;
        len_next   = len;
        sat_next   = sat;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (sig) begin
                    state_next = RUN;
                    len_next   = LBITS'(1);
                    sat_next   = 1'b0;
                end
            end
            RUN: begin
                if (sig) begin
                    if (len != '1) begin
                        len_next = len + LBITS'(1);
                    end else begin
                        sat_next = 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                    push       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO control. When full, a simultaneous pop frees the head slot, which
    // is exactly the slot wr_ptr points at, so the new record lands behind
    // the remaining entries.
    always_comb begin
        full       = (count == (PW+1)'(DEPTH));
        pop        = out_valid & out_ready;
        store      = push & (~full | pop);
        drop       = push & full & ~pop;
        count_next = count;
        if (store && !pop) begin
            count_next = count + (PW+1)'(1);
        end else if (!store && pop) begin
            count_next = count - (PW+1)'(1);
        end
    end

    // State, run length, saturation flag and busy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            len   <= '0;
            sat   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            len   <= len_next;
            sat   <= sat_next;
            busy  <= (state_next == RUN);
        end
    end

    // FIFO storage, pointers, occupancy and event/drop counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            evt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= {sat, len};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count     <= count_next;
            out_valid <= (count_next != '0);
            if (push) begin
                evt_count <= evt_count + 8'd1;
            end
            if (drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Head of the queue; memory is cleared on reset so this reads 0 then.
    assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_full_event_recorder.sv
// Directed testbench for full_event_recorder (LBITS=10, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// that same point, well away from the next edge.
module tb_full_event_recorder;

    logic        clk;
    logic        rst;
    logic        sig;
    logic        out_ready;
    logic        out_valid;
    logic [10:0] out_data;
    logic [7:0]  evt_count;
    logic [7:0]  drop_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    full_event_recorder #(
        .LBITS(10),
        .DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig        (sig),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .evt_count  (evt_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with idle inputs, release between edges.
    task automatic do_reset();
        rst       = 1'b0;
        sig       = 1'b0;
        out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    // One complete run: sig high for n edges, then one low edge.
    task automatic run(input int n);
        sig = 1'b1;
        for (int k = 0; k < n; k++) cycle();
        sig = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        sig       = 1'b0;
        out_ready = 1'b0;
        #3;
        checks++;
        if ({out_valid, out_data, evt_count, drop_count, busy} !== 29'd0) begin
            errors++;
            $display("FAIL reset_init: valid=%b data=%h evt=%0d drop=%0d busy=%b, required all 0",
                     out_valid, out_data, evt_count, drop_count, busy);
        end
        do_reset();
    endtask

    task automatic test_single_run();
        int busy_cycles;
        do_reset();
        out_ready   = 1'b1;
        sig         = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 5) begin
            errors++;
            $display("FAIL single_busy: busy cycles=%0d, required 5", busy_cycles);
        end
        sig = 1'b0;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h005) begin
            errors++;
            $display("FAIL single_record: valid=%b data=%h, required valid=1 data=005", out_valid, out_data);
        end
        checks++;
        if (evt_count !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_evt: evt=%0d busy=%b, required evt=1 busy=0", evt_count, busy);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        run(1023);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h3FF) begin
            errors++;
            $display("FAIL sat_max_len: valid=%b data=%h, required valid=1 data=3ff", out_valid, out_data);
        end
        run(1100);
        checks++;
        if (out_data !== 11'h3FF) begin
            errors++;
            $display("FAIL sat_head_stable: data=%h, required 3ff", out_data);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h7FF) begin
            errors++;
            $display("FAIL sat_record: valid=%b data=%h, required valid=1 data=7ff", out_valid, out_data);
        end
        checks++;
        if (evt_count !== 8'd2 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL sat_counts: evt=%0d drop=%0d, required evt=2 drop=0", evt_count, drop_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int n = 1; n <= 5; n++) run(n);
        checks++;
        if (drop_count !== 8'd1 || evt_count !== 8'd5) begin
            errors++;
            $display("FAIL ovf_counts: drop=%0d evt=%0d, required drop=1 evt=5", drop_count, evt_count);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 11'(i)) begin
                errors++;
                $display("FAIL ovf_drain%0d: valid=%b data=%h, required valid=1 data=%h", i, out_valid, out_data, 11'(i));
            end
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int exp_data [4];
        exp_data = '{2, 3, 4, 7};
        do_reset();
        for (int n = 1; n <= 4; n++) run(n);
        sig = 1'b1;
        for (int k = 0; k < 7; k++) cycle();
        sig       = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (drop_count !== 8'd0 || evt_count !== 8'd5) begin
            errors++;
            $display("FAIL b2b_counts: drop=%0d evt=%0d, required drop=0 evt=5", drop_count, evt_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 11'(exp_data[i])) begin
                errors++;
                $display("FAIL b2b_drain%0d: valid=%b data=%h, required valid=1 data=%h",
                         i, out_valid, out_data, 11'(exp_data[i]));
            end
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run(3);
        sig = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || evt_count !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: valid=%b evt=%0d busy=%b, required valid=1 evt=1 busy=1",
                     out_valid, evt_count, busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, evt_count, drop_count, busy} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h evt=%0d drop=%0d busy=%b, required all 0",
                     out_valid, out_data, evt_count, drop_count, busy);
        end
        sig = 1'b0;
        #1 rst = 1'b1;
        cycle();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        sig = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy: busy=%b, required 1", busy);
        end
        #2 rst = 1'b0;
        sig = 1'b0;
        cycle();
        #2 rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0 || evt_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_discard: valid=%b evt=%0d busy=%b, required valid=0 evt=0 busy=0",
                     out_valid, evt_count, busy);
        end
        sig = 1'b1;
        cycle();
        sig = 1'b0;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h001 || evt_count !== 8'd1) begin
            errors++;
            $display("FAIL midrun_after: valid=%b data=%h evt=%0d, required valid=1 data=001 evt=1",
                     out_valid, out_data, evt_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_saturation();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_event_recorder.md
FULL_EVENT_RECORDER -- requirements
Module: full_event_recorder

Interface
REQ-001 SHALL have parameter LBITS, default 10, giving the run-length field width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the record FIFO depth in entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port sig, input, 1, the full indicator from the upstream load/store volume stage, synchronous to clk.
REQ-006 SHALL have port out_ready, input, 1, meaning the consumer accepts the head record this cycle.
REQ-007 SHALL have port out_valid, output, 1, meaning the FIFO is non-empty and out_data is valid.
REQ-008 SHALL have port out_data, output, LBITS+1, the head record: bit LBITS is the saturation flag and bits LBITS-1:0 are the run length.
REQ-009 SHALL have port evt_count, output, 8, the count of completed full-runs, wrapping modulo 256.
REQ-010 SHALL have port drop_count, output, 8, the count of records lost to a full FIFO, saturating at 255.
REQ-011 SHALL have port busy, output, 1, high while a full-run is being measured.

Function
REQ-012 SHALL run a two-state FSM, IDLE and RUN, that samples sig at every rising clk edge; no separate edge-detect register.
REQ-013 IDLE with sig=1 SHALL go to RUN with len=1 and sat=0.
REQ-014 RUN with sig=1 SHALL set len=len+1 if len<2^LBITS-1; otherwise len holds and sat is set to 1.
REQ-015 RUN with sig=0 SHALL complete the run: go to IDLE, attempt a push of {sat,len}, and increment evt_count.
REQ-016 IDLE with sig=0 SHALL hold all state.
REQ-017 busy SHALL equal (state==RUN), registered.
REQ-018 The FIFO SHALL be first-in first-out, and out_data SHALL be the oldest entry whenever out_valid=1.
REQ-019 out_valid SHALL be (count!=0), registered; a record pushed at edge t SHALL make out_valid high at edge t (zero added latency after the sig=0 sample).
REQ-020 A pop SHALL occur at an edge where out_valid=1 and out_ready=1.
REQ-021 out_ready while out_valid=0 SHALL be ignored.
REQ-022 A push with count<DEPTH SHALL be stored.
REQ-023 A push with count==DEPTH and no pop SHALL be discarded, drop_count SHALL increment (saturating at 255), and FIFO contents SHALL be unchanged.
REQ-024 A push and pop at the same edge SHALL both succeed, including when count==DEPTH; count is unchanged and no drop occurs.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL range 0..DEPTH.
REQ-026 evt_count SHALL increment for every completed run, whether stored or dropped, and SHALL wrap 255->0.
REQ-027 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst=0 SHALL immediately, without clk, force state=IDLE, len=0, sat=0, FIFO empty (pointers and count 0), out_valid=0, out_data=0, evt_count=0, drop_count=0, busy=0.
REQ-029 Reset during RUN SHALL discard the partial run, and no record or evt_count increment SHALL result.
REQ-030 After rst returns to 1, the first sampling edge SHALL behave as IDLE.

Verification
REQ-031 Bench SHALL cover async reset: assert rst=0 between clk edges -> all outputs 0 before the next edge.
REQ-032 Bench SHALL cover a single run: sig=1 for 5 edges then 0, out_ready=1 -> out_valid high one cycle with out_data=0x005, evt_count=1, busy high for 5 cycles.
REQ-033 Bench SHALL cover saturation: sig=1 for 1100 edges -> record out_data=0x7FF (sat=1, len=1023).
REQ-034 Bench SHALL cover overflow: out_ready=0, five runs of lengths 1..5 -> drop_count=1, evt_count=5; draining yields 1,2,3,4 in order.
REQ-035 Bench SHALL cover simultaneous push and pop: FIFO full, run completes on the same edge as out_ready=1 -> count stays 4, drop_count unchanged, new record last out.
REQ-036 Bench SHALL cover reset mid-run: sig=1 for 3 edges, rst=0, then release -> out_valid=0 and evt_count=0.
